// File: rtl/bundled_rx.sv
// Clocked receiver for a 4-phase bundled-data channel: settle, capture, valid/ready hand-off, ack.
// Optional build macro BUNDLED_RX_SYNC_EN inserts a 2-flop synchroniser on req.
module bundled_rx #(
   parameter int   N    = 1,
   parameter int   T    = 1,
   parameter logic Rval = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req,
   input  logic [N-1:0] i,
   output logic         ack,
   output logic [N-1:0] o,
   output logic         o_valid,
   input  logic         o_ready
);

   localparam int CW = $clog2(T) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(T - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] VALID  = 2'd2;
   localparam logic [1:0] ACK    = 2'd3;

   logic          req_s;
   logic [1:0]    state;
   logic [CW-1:0] cnt;

`ifdef BUNDLED_RX_SYNC_EN
   logic req_p0;
   logic req_p1;

   // req crosses into the clk domain here; req_p1 is the first safe sample
   always_ff @(posedge clk) begin
      if (!rst) begin
         req_p0 <= 1'b0;
         req_p1 <= 1'b0;
      end else begin
         req_p0 <= req;
         req_p1 <= req_p0;
      end
   end

   assign req_s = req_p1;
`else
   assign req_s = req;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         o       <= {N{Rval}};
         o_valid <= 1'b0;
         ack     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (req_s) state <= SETTLE;
            end
            SETTLE: begin
               // a request withdrawn before the bundle settles is dropped silently
               if (!req_s) begin
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  o       <= i;
                  o_valid <= 1'b1;
                  state   <= VALID;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            VALID: begin
               if (o_ready) begin
                  o_valid <= 1'b0;
                  ack     <= 1'b1;
                  state   <= ACK;
               end
            end
            ACK: begin
               if (!req_s) begin
                  ack   <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
               ack     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bundled_rx.md
# bundled_rx

Clocked receiver for a 4-phase bundled-data channel. A sender drives an N-bit bundle `i` together with a request `req` that is delayed by a `delay_multi`-style matched delay. This block detects the request and waits T settle cycles so the bundle has stopped moving. It then captures the bundle and presents it on a valid/ready port to synchronous logic. Finally it completes the 4-phase handshake with `ack`. It sits at the boundary where self-timed datapaths hand results into the clocked domain.

## Interface
- `N`, default 1: bundle width in bits, N ≥ 1.
- `T`, default 1: settle cycles between detected `req` rise and capture, T ≥ 1.
- `Rval`, default 1'b0: reset value replicated into every bit of `o`.

- `clk`  input  1  clock, rising edge.
- `rst`  input  1  synchronous, active-low reset (rst=0 at a rising `clk` edge resets).
- `req`  input  1  4-phase request from sender, asynchronous to `clk`.
- `i`  input  N  bundled data; stable from `req` rise until `ack` rise.
- `ack`  output  1  4-phase acknowledge to sender, registered.
- `o`  output  N  captured bundle, registered.
- `o_valid`  output  1  `o` holds an unconsumed capture.
- `o_ready`  input  1  downstream accepts `o` when high with `o_valid`.

## Operation
- `req_s` is the internal view of `req`: synchronised or raw, per Configuration.
- FSM states are IDLE, SETTLE, VALID and ACK.
- IDLE:
  - `req_s`=1 → SETTLE, and the counter `cnt` is cleared to 0.
  - `req_s`=0 → stay in IDLE.
- SETTLE:
  - `cnt` increments each cycle.
  - When `cnt`==T-1 and `req_s`=1: capture `i` into `o` and go to VALID.
  - If `req_s`=0 at any SETTLE cycle (protocol violation): abort to IDLE. No capture, `o` unchanged, `ack` stays 0.
- VALID:
  - `o_valid`=1.
  - On `o_ready`=1 → ACK: `o_valid` drops and `ack` rises on that edge.
  - `req_s` changes are ignored in VALID.
- ACK:
  - `ack`=1.
  - On `req_s`=0 → IDLE and `ack` drops.
  - `req_s` staying 1 holds ACK indefinitely.
- `o` holds the last captured value until the next capture. It never changes outside the SETTLE→VALID edge or reset.
- `cnt` is $clog2(T)+1 bits wide. It is never compared beyond T-1, so there is no wrap.
- Reset (rst=0), including mid-operation:
  - State → IDLE, `cnt` → 0, `o` → {N{Rval}}, `o_valid` → 0, `ack` → 0, synchroniser flops → 0.
  - The next transaction starts only from a fresh `req_s` rise after reset release. If `req` is still high at release, it is treated as a new request.

## Timing
- Edge 0 is the first edge at which `req_s`=1 is sampled in IDLE.
- `o` and `o_valid` update after edge T, so `o_valid` is high in cycle T+1.
- Best case (`o_ready` held at 1): `ack` rises after edge T+1.
- `ack` falls one edge after `req_s`=0 is sampled in ACK.
- With synchronisation, add 2 cycles from a `req` pin change to `req_s` on both rise and fall.
- Full 4-phase cycle time with `o_ready`=1 and an immediate sender is T+4 edges of `req_s` activity, plus 2+2 synchroniser cycles.
- No combinational path from any input to any output.

## Configuration
- `BUNDLED_RX_SYNC_EN` defined: `req` passes through a 2-flop synchroniser, reset to 0, before the FSM. `req_s` lags `req` by 2 cycles. Use this when the sender is truly asynchronous.
- Not defined: `req_s`=`req` directly, with zero added latency. The sender must then be synchronous to `clk`.
- `ack`, `o` and FSM behaviour are otherwise identical in both builds.

## Test plan
- **Reset values:** N=8, Rval=1 → during rst=0, `o`=8'hFF, `o_valid`=0, `ack`=0. These hold for 2 cycles after release with `req`=0.
- **Basic transfer:** N=8, T=3, sync off, `o_ready`=1. `i`=8'hA5, `req` rises before edge 0 → `o`=8'hA5 and `o_valid`=1 in cycle 4, `ack`=1 in cycle 5. Drop `req` → `ack`=0 one edge later.
- **Backpressure:** same stimulus with `o_ready`=0 for 10 cycles → `o_valid` stays 1, `ack` stays 0, `o` stable. Change `i` to 8'h3C during the stall → `o` stays 8'hA5. Raise `o_ready` → `ack` rises on the next edge.
- **Abort:** T=4, `req` high for 2 cycles then low in SETTLE → no `o_valid`, no `ack`, `o` keeps its previous value, state returns to IDLE. A following legal request of 8'h11 completes normally.
- **Mid-operation reset:** assert rst=0 while in ACK with `req`=1 → `ack`=0 and `o`=Rval. After release with `req` still 1, a new capture occurs T edges later.
- **Sync build:** with `BUNDLED_RX_SYNC_EN`, same as the basic-transfer case → `o_valid` rises 2 cycles later (cycle 6). `ack` fall lags `req` fall by 3 edges.
